// File: rtl/fx_pkg.sv
// fx bus slave shared definitions.
// Field widths, register offsets and STAT/CTRL bit positions.
package fx_pkg;

  localparam int ADDR_W = 22;
  localparam int PAGE_W = 6;
  localparam int OFS_W  = 8;

  localparam logic [OFS_W-1:0] OFS_ID     = 8'h00;
  localparam logic [OFS_W-1:0] OFS_CTRL   = 8'h01;
  localparam logic [OFS_W-1:0] OFS_CFG0   = 8'h02;
  localparam logic [OFS_W-1:0] OFS_CFG1   = 8'h03;
  localparam logic [OFS_W-1:0] OFS_CFG2   = 8'h04;
  localparam logic [OFS_W-1:0] OFS_CFG3   = 8'h05;
  localparam logic [OFS_W-1:0] OFS_STAT   = 8'h06;
  localparam logic [OFS_W-1:0] OFS_SCLR   = 8'h07;
  localparam logic [OFS_W-1:0] OFS_LEVEL  = 8'h08;
  localparam logic [OFS_W-1:0] OFS_FIFO   = 8'h09;
  localparam logic [OFS_W-1:0] OFS_CNT_LO = 8'h0A;
  localparam logic [OFS_W-1:0] OFS_CNT_HI = 8'h0B;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

endpackage

// File: rtl/fx_sfifo.sv
// Synchronous FIFO with sticky overflow flag.
// Pop on empty is ignored; push on full is accepted only alongside a pop.
module fx_sfifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic          ovf_clr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (level == '0);
  assign full    = (level == DEPTH);
  assign dout    = empty ? '0 : mem[rptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !clr)
      mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (do_pop && !do_push)
        level <= level - 1'b1;
    end
  end

  // a new overflow wins over a same-cycle clear so no event is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf <= 1'b0;
    else if (push && full && !do_pop && !clr)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end

endmodule

// File: rtl/fx_slave_port.sv
// fx bus slave endpoint: decode, register bank,
// event counter, push FIFO and registered read mux.
module fx_slave_port
  import fx_pkg::*;
#(
  parameter logic [5:0] DEV_PAGE = 6'h02,
  parameter logic [7:0] VERSION  = 8'h10,
  parameter int         FIFO_AW  = 4
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              fx_wr,
  input  logic [ADDR_W-1:0] fx_waddr,
  input  logic [7:0]        fx_data,
  input  logic              fx_rd,
  input  logic [ADDR_W-1:0] fx_raddr,
  output logic [7:0]        fx_q,
  output logic [31:0]       cfg,
  output logic              en,
  input  logic              ev_valid,
  input  logic [7:0]        ev_data,
  input  logic              evt_pulse
);

  logic              wr_hit;
  logic              rd_hit;
  logic [OFS_W-1:0]  wofs;
  logic [OFS_W-1:0]  rofs;
  logic [15:0]       cnt;
  logic [7:0]        snap;
  logic [7:0]        rdata;
  logic              f_pop;
  logic              f_clr;
  logic              f_oclr;
  logic [7:0]        f_dout;
  logic              f_full;
  logic              f_empty;
  logic              f_ovf;
  logic [FIFO_AW:0]  f_level;

  assign wofs   = fx_waddr[OFS_W-1:0];
  assign rofs   = fx_raddr[OFS_W-1:0];
  assign wr_hit = fx_wr && fx_waddr[21:16] == DEV_PAGE
               && fx_waddr[15:8] == 8'h00;
  assign rd_hit = fx_rd && fx_raddr[21:16] == DEV_PAGE
               && fx_raddr[15:8] == 8'h00;

  assign f_pop  = rd_hit && rofs == OFS_FIFO;
  assign f_clr  = wr_hit && wofs == OFS_CTRL
               && fx_data[CTRL_CLR];
  assign f_oclr = wr_hit && wofs == OFS_SCLR
               && fx_data[0];

  fx_sfifo #(
    .W  (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk_sys),
    .rst     (rst),
    .push    (ev_valid && en),
    .pop     (f_pop),
    .clr     (f_clr),
    .ovf_clr (f_oclr),
    .din     (ev_data),
    .dout    (f_dout),
    .full    (f_full),
    .empty   (f_empty),
    .level   (f_level),
    .ovf     (f_ovf)
  );

  always_comb begin
    rdata = 8'h00;
    unique case (1'b1)
      rofs == OFS_ID:     rdata = VERSION;
      rofs == OFS_CTRL:   rdata = {7'b0, en};
      rofs == OFS_CFG0:   rdata = cfg[7:0];
      rofs == OFS_CFG1:   rdata = cfg[15:8];
      rofs == OFS_CFG2:   rdata = cfg[23:16];
      rofs == OFS_CFG3:   rdata = cfg[31:24];
      rofs == OFS_STAT:   rdata = {5'b0, f_ovf,
                                   f_full, f_empty};
      rofs == OFS_LEVEL:  rdata = 8'(f_level);
      rofs == OFS_FIFO:   rdata = f_dout;
      rofs == OFS_CNT_LO: rdata = cnt[7:0];
      rofs == OFS_CNT_HI: rdata = snap;
      default:            rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      fx_q <= 8'h00;
      snap <= 8'h00;
    end else if (fx_rd) begin
      fx_q <= rd_hit ? rdata : 8'h00;
      if (rd_hit && rofs == OFS_CNT_LO)
        snap <= cnt[15:8];
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      en  <= 1'b0;
      cfg <= 32'h0;
    end else if (wr_hit) begin
      unique case (1'b1)
        wofs == OFS_CTRL: en          <= fx_data[CTRL_EN];
        wofs == OFS_CFG0: cfg[7:0]    <= fx_data;
        wofs == OFS_CFG1: cfg[15:8]   <= fx_data;
        wofs == OFS_CFG2: cfg[23:16]  <= fx_data;
        wofs == OFS_CFG3: cfg[31:24]  <= fx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)
      cnt <= 16'h0;
    else if (evt_pulse && en)
      cnt <= cnt + 16'h1;
  end

endmodule

// File: tb/tb_fx_slave_port.sv
// Directed bench for fx_slave_port with a queue-based
// register/FIFO model checked on every falling edge.
module tb_fx_slave_port;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        fx_wr = 1'b0;
  logic [21:0] fx_waddr = '0;
  logic [7:0]  fx_data = '0;
  logic        fx_rd = 1'b0;
  logic [21:0] fx_raddr = '0;
  logic [7:0]  fx_q;
  logic [31:0] cfg;
  logic        en;
  logic        ev_valid = 1'b0;
  logic [7:0]  ev_data = '0;
  logic        evt_pulse = 1'b0;

  int total = 0;
  int bad = 0;

  fx_slave_port dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .fx_wr     (fx_wr),
    .fx_waddr  (fx_waddr),
    .fx_data   (fx_data),
    .fx_rd     (fx_rd),
    .fx_raddr  (fx_raddr),
    .fx_q      (fx_q),
    .cfg       (cfg),
    .en        (en),
    .ev_valid  (ev_valid),
    .ev_data   (ev_data),
    .evt_pulse (evt_pulse)
  );

  always #5 clk_sys = ~clk_sys;

  // model state
  logic [7:0]  m_q;
  logic [7:0]  m_cfg [4];
  bit          m_en;
  bit          m_ovf;
  int          m_cnt;
  logic [7:0]  m_snap;
  logic [7:0]  m_fifo [$];

  function automatic bit hit(input logic [21:0] a);
    return a[21:16] == 6'h02 && a[15:8] == 8'h00;
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] o);
    int n;
    n = m_fifo.size();
    case (o)
      8'h00: return 8'h10;
      8'h01: return {7'b0, m_en};
      8'h02, 8'h03, 8'h04, 8'h05: return m_cfg[o - 8'h02];
      8'h06: return {5'b0, m_ovf, n == 16, n == 0};
      8'h08: return 8'(n);
      8'h09: return (n == 0) ? 8'h00 : m_fifo[0];
      8'h0A: return 8'(m_cnt % 256);
      8'h0B: return m_snap;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      m_q = 0; m_en = 0; m_ovf = 0; m_cnt = 0; m_snap = 0;
      for (int i = 0; i < 4; i++) m_cfg[i] = 0;
      m_fifo.delete();
    end else begin
      bit rh, wh, popr, clr, en_old;
      int n;
      logic [7:0] ro, wo;
      rh = fx_rd && hit(fx_raddr);
      wh = fx_wr && hit(fx_waddr);
      ro = fx_raddr[7:0];
      wo = fx_waddr[7:0];
      en_old = m_en;
      n = m_fifo.size();
      if (fx_rd) m_q = rh ? m_read(ro) : 8'h00;
      if (rh && ro == 8'h0A) m_snap = 8'(m_cnt / 256);
      popr = rh && ro == 8'h09 && n > 0;
      clr = wh && wo == 8'h01 && fx_data[1];
      if (wh && wo == 8'h07 && fx_data[0]) m_ovf = 0;
      if (clr) m_fifo.delete();
      else begin
        if (popr) void'(m_fifo.pop_front());
        if (ev_valid && en_old) begin
          if (n == 16 && !popr) m_ovf = 1;
          else m_fifo.push_back(ev_data);
        end
      end
      if (wh && wo == 8'h01) m_en = fx_data[0];
      if (wh && wo >= 8'h02 && wo <= 8'h05)
        m_cfg[wo - 8'h02] = fx_data;
      if (evt_pulse && en_old) m_cnt = (m_cnt + 1) % 65536;
    end
  end

  always @(negedge clk_sys) begin
    total++;
    if (fx_q !== m_q) begin
      bad++;
      $display("FAIL model_fx_q got=%h want=%h t=%0t", fx_q, m_q, $time);
    end
    total++;
    if (cfg !== {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]}) begin
      bad++;
      $display("FAIL model_cfg got=%h t=%0t", cfg, $time);
    end
    total++;
    if (en !== m_en) begin
      bad++;
      $display("FAIL model_en got=%b want=%b t=%0t", en, m_en, $time);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // all tasks start and end 1 time unit after a rising edge
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [21:0] a, input logic [7:0] d);
    fx_wr = 1; fx_waddr = a; fx_data = d;
    step();
    fx_wr = 0;
  endtask

  task automatic rd(input string nm, input logic [21:0] a,
                    input logic [7:0] exp);
    fx_rd = 1; fx_raddr = a;
    step();
    fx_rd = 0;
    chk(nm, {24'h0, fx_q}, {24'h0, exp});
  endtask

  task automatic pulses(input int n);
    evt_pulse = 1;
    repeat (n) @(posedge clk_sys);
    #1;
    evt_pulse = 0;
  endtask

  initial begin
    #12 rst = 0;
    step();
    chk("reset_q", {24'h0, fx_q}, 32'h0);
    chk("reset_cfg", cfg, 32'h0);
    chk("reset_en", {31'h0, en}, 32'h0);
    rd("id", 22'h020000, 8'h10);
    rd("page_miss", 22'h030000, 8'h00);
    rd("mid_miss", 22'h020100, 8'h00);
    rd("level0", 22'h020008, 8'h00);
    step();
    chk("q_hold", {24'h0, fx_q}, 32'h0);

    wr(22'h020002, 8'h11);
    wr(22'h020003, 8'h22);
    wr(22'h020004, 8'h33);
    wr(22'h020005, 8'h44);
    chk("cfg_word", cfg, 32'h44332211);
    rd("cfg2", 22'h020004, 8'h33);
    step();
    chk("q_hold_cfg", {24'h0, fx_q}, 32'h33);
    wr(22'h030002, 8'hEE);
    chk("wr_miss", cfg, 32'h44332211);

    fx_wr = 1; fx_waddr = 22'h020002; fx_data = 8'h99;
    rd("same_cycle_old", 22'h020002, 8'h11);
    fx_wr = 0;
    rd("same_cycle_new", 22'h020002, 8'h99);

    wr(22'h020001, 8'h01);
    for (int i = 0; i < 17; i++) begin
      ev_valid = 1; ev_data = 8'(i);
      step();
    end
    ev_valid = 0;
    rd("level_full", 22'h020008, 8'h10);
    rd("stat_full_ovf", 22'h020006, 8'h06);
    for (int i = 0; i < 16; i++)
      rd($sformatf("pop%0d", i), 22'h020009, 8'(i));
    rd("pop_empty", 22'h020009, 8'h00);
    rd("stat_empty_ovf", 22'h020006, 8'h05);
    wr(22'h020007, 8'h01);
    rd("stat_clr", 22'h020006, 8'h01);

    for (int i = 0; i < 3; i++) begin
      ev_valid = 1; ev_data = 8'hA0 + 8'(i);
      step();
    end
    ev_valid = 0;
    rd("level3", 22'h020008, 8'h03);
    wr(22'h020001, 8'h03);
    rd("level_clr", 22'h020008, 8'h00);
    rd("ctrl_rd", 22'h020001, 8'h01);

    ev_valid = 1; ev_data = 8'h5A;
    fx_rd = 1; fx_raddr = 22'h020009;
    rd("pop_push_empty", 22'h020009, 8'h00);
    ev_valid = 0;
    rd("level_pp", 22'h020008, 8'h01);
    rd("pp_data", 22'h020009, 8'h5A);

    pulses(16'h1234);
    rd("cnt_lo", 22'h02000A, 8'h34);
    pulses(4);
    rd("cnt_hi", 22'h02000B, 8'h12);
    pulses(16'hEDCC - 4);
    rd("wrap_lo", 22'h02000A, 8'h00);
    rd("wrap_hi", 22'h02000B, 8'h00);

    for (int i = 0; i < 4; i++) begin
      ev_valid = 1; ev_data = 8'(i);
      step();
    end
    rd("cfg1_pre", 22'h020003, 8'h22);
    ev_valid = 1;
    #3 rst = 1;
    #1;
    chk("async_en", {31'h0, en}, 32'h0);
    chk("async_cfg", cfg, 32'h0);
    chk("async_q", {24'h0, fx_q}, 32'h0);
    ev_valid = 0;
    step();
    rst = 0;
    step();
    rd("post_level", 22'h020008, 8'h00);
    rd("post_id", 22'h020000, 8'h10);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
